// File: rtl/bcd_convert_seq.sv
`timescale 1ns/1ps
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Latency: WIDTH+1 clocks from the accepted start edge to the done pulse.
// No backpressure: start is only honoured while idle; requests made while busy are dropped.
module bcd_convert_seq #(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clkP,
  input  logic                  resP,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binIn,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcdOut,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  // Count value seen on the edge that performs the final shift step
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    stIdle,
    stShift,
    stDone
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] binReg;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adjusted;
  logic             ovf;
  logic [CW-1:0]    cnt;

  // Add-3 correction on every digit of the pre-shift scratch value, in parallel
  always_comb begin
    adjusted = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM with registered handshake and result outputs
  always_ff @(posedge clkP) begin
    if (resP) begin
      state    <= stIdle;
      binReg   <= '0;
      scratch  <= '0;
      ovf      <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcdOut   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        stIdle: begin
          if (start) begin
            binReg  <= binIn;
            scratch <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= stShift;
          end
        end
        stShift: begin
          // A bit leaving the top digit means the value needs more digits than we have
          ovf     <= ovf | adjusted[BW-1];
          scratch <= {adjusted[BW-2:0], binReg[WIDTH-1]};
          binReg  <= {binReg[WIDTH-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state <= stDone;
          end
        end
        stDone: begin
          bcdOut   <= scratch;
          overflow <= ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= stIdle;
        end
        default: begin
          state <= stIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_seq.sv
`timescale 1ns/1ps
// Directed bench for bcd_convert_seq: default 3-digit instance plus a 2-digit overflow instance.
// Inputs change just after the falling edge, outputs are compared on the falling edge.
// Both instances share clock, reset, start and binIn.
module tb_bcd_convert_seq;

  logic        clkP = 1'b0;
  logic        resP;
  logic        start;
  logic [8:0]  binIn;
  logic        busy, done, overflow;
  logic [11:0] bcdOut;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcdOut2;

  int errors = 0;
  int checks = 0;
  int lat;
  int pulses;
  int expBcd;

  always #5 clkP = ~clkP;

  bcd_convert_seq #(.WIDTH(9), .DIGITS(3)) dut (
    .clkP(clkP), .resP(resP), .start(start), .binIn(binIn),
    .busy(busy), .done(done), .bcdOut(bcdOut), .overflow(overflow)
  );

  bcd_convert_seq #(.WIDTH(9), .DIGITS(2)) dut2 (
    .clkP(clkP), .resP(resP), .start(start), .binIn(binIn),
    .busy(busy2), .done(done2), .bcdOut(bcdOut2), .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns with done observed (or after a bounded wait)
  task automatic convert(input logic [8:0] v, output int latency);
    start = 1'b1;
    binIn = v;
    @(negedge clkP);
    start = 1'b0;
    latency = 0;
    while (!done && latency < 40) begin
      @(negedge clkP);
      latency++;
    end
  endtask

  initial begin
    resP  = 1'b1;
    start = 1'b0;
    binIn = '0;
    repeat (2) @(negedge clkP);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_bcd", bcdOut, 12'h000);
    chk("reset_ovf", overflow, 1'b0);
    resP = 1'b0;
    @(negedge clkP);

    // 1: zero input, latency and busy timing
    convert(9'd0, lat);
    chk("zero_latency", lat, 10);
    chk("zero_bcd", bcdOut, 12'h000);
    chk("zero_ovf", overflow, 1'b0);
    chk("zero_busy_at_done", busy, 1'b0);
    @(negedge clkP);
    chk("zero_done_one_cycle", done, 1'b0);

    // 2: assorted values
    convert(9'd511, lat);
    chk("v511_latency", lat, 10);
    chk("v511_bcd", bcdOut, 12'h511);
    chk("v511_ovf", overflow, 1'b0);
    convert(9'd255, lat);
    chk("v255_bcd", bcdOut, 12'h255);
    convert(9'd100, lat);
    chk("v100_bcd", bcdOut, 12'h100);
    @(negedge clkP);

    // 3: second start while busy is ignored
    start = 1'b1;
    binIn = 9'd37;
    @(negedge clkP);
    start = 1'b0;
    lat = 0;
    repeat (2) begin
      @(negedge clkP);
      lat++;
    end
    chk("ignored_busy", busy, 1'b1);
    start = 1'b1;
    binIn = 9'd400;
    @(negedge clkP);
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clkP);
      lat++;
    end
    chk("ignored_latency", lat, 10);
    chk("ignored_bcd", bcdOut, 12'h037);
    pulses = 0;
    repeat (12) begin
      @(negedge clkP);
      if (done) pulses++;
    end
    chk("ignored_single_done", pulses, 0);
    chk("ignored_idle_after", busy, 1'b0);
    chk("ignored_bcd_held", bcdOut, 12'h037);

    // 4: reset mid-conversion discards it
    start = 1'b1;
    binIn = 9'd200;
    @(negedge clkP);
    start = 1'b0;
    repeat (4) @(negedge clkP);
    resP = 1'b1;
    @(negedge clkP);
    resP = 1'b0;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_done", done, 1'b0);
    chk("midreset_bcd", bcdOut, 12'h000);
    chk("midreset_ovf", overflow, 1'b0);
    pulses = 0;
    repeat (15) begin
      @(negedge clkP);
      if (done) pulses++;
    end
    chk("midreset_no_done", pulses, 0);
    convert(9'd88, lat);
    chk("after_reset_latency", lat, 10);
    chk("after_reset_bcd", bcdOut, 12'h088);

    // 5: start held high gives back-to-back conversions every 11 clocks
    @(negedge clkP);
    start = 1'b1;
    binIn = 9'd12;
    @(negedge clkP);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clkP);
      lat++;
    end
    chk("b2b_first_latency", lat, 10);
    chk("b2b_first_bcd", bcdOut, 12'h012);
    binIn = 9'd345;
    lat = 0;
    do begin
      @(negedge clkP);
      lat++;
    end while (!done && lat < 40);
    chk("b2b_period", lat, 11);
    chk("b2b_second_bcd", bcdOut, 12'h345);
    start = 1'b0;
    @(negedge clkP);
    chk("b2b_idle_after", busy, 1'b0);

    // 6: two-digit instance overflow behaviour
    convert(9'd123, lat);
    chk("d2_123_bcd", bcdOut2, 8'h23);
    chk("d2_123_ovf", overflow2, 1'b1);
    chk("d2_123_done", done2, 1'b1);
    chk("d3_123_bcd", bcdOut, 12'h123);
    chk("d3_123_ovf", overflow, 1'b0);
    convert(9'd99, lat);
    chk("d2_99_bcd", bcdOut2, 8'h99);
    chk("d2_99_ovf", overflow2, 1'b0);

    // Sweep against integer decimal decomposition
    for (int v = 0; v < 512; v++) begin
      convert(9'(v), lat);
      expBcd = ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
      chk($sformatf("sweep_bcd_%0d", v), bcdOut, expBcd);
      chk($sformatf("sweep_ovf_%0d", v), overflow, 1'b0);
      chk($sformatf("sweep_d2_bcd_%0d", v), bcdOut2, (((v / 10) % 10) << 4) | (v % 10));
      chk($sformatf("sweep_d2_ovf_%0d", v), overflow2, (v >= 100) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
